// File: rtl/ln_pkg.sv
// Shared constants for the 64 x FP16 layer-norm datapath and its feeder.
package ln_pkg;

  localparam int unsigned LN_DW     = 16;
  localparam int unsigned LN_N_ELEM = 64;
  localparam int unsigned LN_LANES  = 8;
  localparam int unsigned LN_BEATS  = LN_N_ELEM / LN_LANES;

  // Counter width that stays legal when a vector fits in a single beat.
  function automatic int unsigned beat_w(input int unsigned beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

  localparam int unsigned LN_BEAT_W = beat_w(LN_BEATS);

endpackage

// File: rtl/ln_vec_feeder.sv
// Packs a narrow FP16 beat stream into full LN input vectors through a two-slot buffer.
module ln_vec_feeder
  import ln_pkg::*;
#(
  parameter int unsigned N_ELEM = LN_N_ELEM,
  parameter int unsigned DW     = LN_DW,
  parameter int unsigned LANES  = LN_LANES,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   s_valid,
  input  logic [LANES*DW-1:0]    s_data,
  input  logic                   s_last,
  output logic                   s_ready,
  input  logic                   flush,
  output logic                   x_valid,
  output logic [N_ELEM*DW-1:0]   a,
  input  logic                   x_ready,
  output logic                   err_len,
  output logic [CNT_W-1:0]       vec_count
);

  localparam int unsigned BEATS     = N_ELEM / LANES;
  localparam int unsigned BW        = beat_w(BEATS);
  localparam int unsigned VW        = N_ELEM * DW;
  localparam int unsigned BEAT_BITS = LANES * DW;

  logic [VW-1:0]    slot_q [2];
  logic [VW-1:0]    slot_d [2];
  logic [1:0]       full_q, full_d;
  logic             wr_sel_q, wr_sel_d;
  logic             rd_sel_q, rd_sel_d;
  logic [BW-1:0]    beat_cnt_q, beat_cnt_d;
  logic             err_len_q, err_len_d;
  logic [CNT_W-1:0] vec_count_q, vec_count_d;

  logic accept, pop, last_beat;

  assign s_ready   = !full_q[wr_sel_q];
  assign x_valid   = full_q[rd_sel_q];
  assign a         = slot_q[rd_sel_q];
  assign err_len   = err_len_q;
  assign vec_count = vec_count_q;

  assign accept    = s_valid && s_ready;
  assign pop       = x_valid && x_ready;
  assign last_beat = (beat_cnt_q == BW'(BEATS - 1));

  always_comb begin
    slot_d      = slot_q;
    full_d      = full_q;
    wr_sel_d    = wr_sel_q;
    rd_sel_d    = rd_sel_q;
    beat_cnt_d  = beat_cnt_q;
    err_len_d   = 1'b0;
    vec_count_d = vec_count_q;

    if (flush) begin
      // Slot contents are left as-is; they are unreachable once full is clear.
      full_d     = '0;
      beat_cnt_d = '0;
      wr_sel_d   = 1'b0;
      rd_sel_d   = 1'b0;
    end else begin
      if (pop) begin
        full_d[rd_sel_q] = 1'b0;
        rd_sel_d         = !rd_sel_q;
        vec_count_d      = vec_count_q + CNT_W'(1);
      end
      if (accept) begin
        slot_d[wr_sel_q][int'(beat_cnt_q) * BEAT_BITS +: BEAT_BITS] = s_data;
        if (last_beat) begin
          full_d[wr_sel_q] = 1'b1;
          wr_sel_d         = !wr_sel_q;
          beat_cnt_d       = '0;
          err_len_d        = !s_last;
        end else if (s_last) begin
          // Short frame: drop the partial vector, the slot stays free.
          beat_cnt_d = '0;
          err_len_d  = 1'b1;
        end else begin
          beat_cnt_d = beat_cnt_q + BW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q      <= '{default: '0};
      full_q      <= '0;
      wr_sel_q    <= 1'b0;
      rd_sel_q    <= 1'b0;
      beat_cnt_q  <= '0;
      err_len_q   <= 1'b0;
      vec_count_q <= '0;
    end else begin
      slot_q      <= slot_d;
      full_q      <= full_d;
      wr_sel_q    <= wr_sel_d;
      rd_sel_q    <= rd_sel_d;
      beat_cnt_q  <= beat_cnt_d;
      err_len_q   <= err_len_d;
      vec_count_q <= vec_count_d;
    end
  end

endmodule

// File: tb/tb_ln_vec_feeder.sv
// Bench for ln_vec_feeder: frame table plus hand sequences, vectors checked via a scoreboard.
module tb_ln_vec_feeder;

  localparam int unsigned DW     = 16;
  localparam int unsigned N_ELEM = 64;
  localparam int unsigned LANES  = 8;
  localparam int unsigned BEATS  = N_ELEM / LANES;
  localparam int unsigned CNT_W  = 16;

  typedef logic [N_ELEM*DW-1:0] vec_t;
  typedef logic [LANES*DW-1:0]  beat_t;

  typedef struct {
    int nbeats;
    int last_at;
    int exp_commit;
    int exp_err;
  } frame_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              s_valid;
  beat_t             s_data;
  logic              s_last;
  logic              s_ready;
  logic              flush;
  logic              x_valid;
  vec_t              a;
  logic              x_ready;
  logic              err_len;
  logic [CNT_W-1:0]  vec_count;

  ln_vec_feeder #(
    .N_ELEM(N_ELEM),
    .DW    (DW),
    .LANES (LANES),
    .CNT_W (CNT_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .s_valid  (s_valid),
    .s_data   (s_data),
    .s_last   (s_last),
    .s_ready  (s_ready),
    .flush    (flush),
    .x_valid  (x_valid),
    .a        (a),
    .x_ready  (x_ready),
    .err_len  (err_len),
    .vec_count(vec_count)
  );

  always #5 clk = !clk;

  int   tests = 0;
  int   fails = 0;
  vec_t sb[$];
  vec_t asm_vec;
  int   tb_beat = 0;
  int   err_exp = 0;
  int   err_seen = 0;
  int   exp_cnt = 0;
  int   stalls = 0;
  int   beats_acc = 0;
  bit   held = 0;
  vec_t a_prev;
  bit   stream_done;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_vec(input string name, input vec_t act, input vec_t exp);
    tests++;
    if (act !== exp) begin
      fails++;
      for (int i = 0; i < int'(N_ELEM); i++) begin
        if (act[i*DW +: DW] !== exp[i*DW +: DW]) begin
          $display("FAIL %s: element %0d got %h expected %h", name, i,
                   act[i*DW +: DW], exp[i*DW +: DW]);
          break;
        end
      end
    end
  endtask

  // Output monitor and scoreboard consumer.
  always @(negedge clk) begin
    if (rst_n) begin
      if (err_len) err_seen++;
      if (!flush) begin
        if (s_valid && !s_ready) stalls++;
        if (x_valid) begin
          if (held) check_vec("a_stable", a, a_prev);
          if (x_ready) begin
            if (sb.size() == 0) begin
              check("unexpected_output", 32'd1, 32'd0);
            end else begin
              check_vec("a_order", a, sb.pop_front());
            end
            exp_cnt++;
            held = 0;
          end else begin
            held   = 1;
            a_prev = a;
          end
        end else begin
          held = 0;
        end
      end else begin
        held = 0;
      end
    end else begin
      held = 0;
    end
  end

  // Drive one beat and hold it until accepted; update the reference model on acceptance.
  task automatic send_beat(input beat_t data, input logic last);
    bit ok = 0;
    s_valid = 1'b1;
    s_data  = data;
    s_last  = last;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (s_ready) begin
        ok = 1;
        break;
      end
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
    if (!ok) begin
      check("beat_accept_timeout", 32'd0, 32'd1);
      return;
    end
    beats_acc++;
    asm_vec[tb_beat*LANES*DW +: LANES*DW] = data;
    if (tb_beat == int'(BEATS) - 1) begin
      sb.push_back(asm_vec);
      if (!last) err_exp++;
      tb_beat = 0;
    end else if (last) begin
      err_exp++;
      tb_beat = 0;
    end else begin
      tb_beat++;
    end
  endtask

  task automatic send_vec(input int base, input int nbeats, input int last_at);
    beat_t d;
    for (int b = 0; b < nbeats; b++) begin
      for (int k = 0; k < int'(LANES); k++) d[k*DW +: DW] = 16'(base + b * int'(LANES) + k);
      send_beat(d, b == last_at);
    end
  endtask

  task automatic drain();
    int c = 0;
    repeat (3) @(negedge clk);
    while ((sb.size() != 0 || x_valid) && c < 500) begin
      @(negedge clk);
      c++;
    end
    check("drain_timeout", 32'(c < 500), 32'd1);
    @(posedge clk);
    #1;
  endtask

  frame_t frames[5];

  initial begin
    int cnt0, err0, g;
    frames[0] = '{nbeats: 8, last_at: 7,  exp_commit: 1, exp_err: 0};
    frames[1] = '{nbeats: 4, last_at: 3,  exp_commit: 0, exp_err: 1};
    frames[2] = '{nbeats: 8, last_at: -1, exp_commit: 1, exp_err: 1};
    frames[3] = '{nbeats: 2, last_at: 1,  exp_commit: 0, exp_err: 1};
    frames[4] = '{nbeats: 8, last_at: 7,  exp_commit: 1, exp_err: 0};

    rst_n = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0; flush = 1'b0; x_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_x_valid", 32'(x_valid), 32'd0);
    check("rst_s_ready", 32'(s_ready), 32'd1);
    check("rst_err_len", 32'(err_len), 32'd0);
    check("rst_vec_count", 32'(vec_count), 32'd0);
    check("rst_a_zero", 32'(a == '0), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single vector with latency check.
    send_vec(16'h3C00, 8, 7);
    @(negedge clk);
    check("single_x_valid_hop", 32'(x_valid), 32'd1);
    check("single_elem5", 32'(a[5*DW +: DW]), 32'h3C05);
    @(negedge clk);
    check("single_x_valid_one_cycle", 32'(x_valid), 32'd0);
    check("single_vec_count", 32'(vec_count), 32'd1);
    check("single_no_err", 32'(err_seen), 32'd0);
    @(posedge clk); #1;

    // Framing table.
    for (int f = 0; f < 5; f++) begin
      cnt0 = int'(vec_count);
      err0 = err_seen;
      send_vec(16'h1000 * (f + 1), frames[f].nbeats, frames[f].last_at);
      drain();
      check($sformatf("frame%0d_commit", f), 32'(int'(vec_count) - cnt0), 32'(frames[f].exp_commit));
      check($sformatf("frame%0d_err", f), 32'(err_seen - err0), 32'(frames[f].exp_err));
    end
    check("frame_err_model", 32'(err_seen), 32'(err_exp));

    // Back-pressure: three vectors with x_ready low.
    cnt0 = int'(vec_count);
    x_ready = 1'b0;
    beats_acc = 0;
    stream_done = 0;
    fork
      begin
        for (int v = 0; v < 3; v++) send_vec(16'h7000 + v * 16'h100, 8, 7);
        stream_done = 1;
      end
    join_none
    g = 0;
    while (beats_acc < 16 && g < 500) begin
      @(negedge clk);
      g++;
    end
    check("bp_16_beats", 32'(beats_acc), 32'd16);
    check("bp_s_ready_low", 32'(s_ready), 32'd0);
    check("bp_x_valid", 32'(x_valid), 32'd1);
    repeat (6) @(negedge clk);
    check("bp_still_blocked", 32'(beats_acc), 32'd16);
    @(posedge clk); #1;
    x_ready = 1'b1;
    g = 0;
    while (!stream_done && g < 500) begin
      @(negedge clk);
      g++;
    end
    check("bp_stream_done", 32'(stream_done), 32'd1);
    drain();
    check("bp_vec_count", 32'(int'(vec_count) - cnt0), 32'd3);
    check("bp_s_ready_back", 32'(s_ready), 32'd1);

    // Streaming: 80 beats back to back with x_ready high.
    cnt0 = int'(vec_count);
    stalls = 0;
    for (int v = 0; v < 10; v++) send_vec(16'h2000 + v * 64, 8, 7);
    check("stream_no_stall", 32'(stalls), 32'd0);
    drain();
    check("stream_vec_count", 32'(int'(vec_count) - cnt0), 32'd10);

    // Flush with one slot full and a partial vector.
    cnt0 = int'(vec_count);
    x_ready = 1'b0;
    send_vec(16'h5000, 8, 7);
    send_vec(16'h5100, 5, -1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    sb.delete();
    tb_beat = 0;
    @(negedge clk);
    check("flush_x_valid", 32'(x_valid), 32'd0);
    check("flush_s_ready", 32'(s_ready), 32'd1);
    check("flush_count_kept", 32'(vec_count), 32'(cnt0));
    @(posedge clk); #1;
    x_ready = 1'b1;
    send_vec(16'h6000, 8, 7);
    drain();
    check("flush_after_vec", 32'(int'(vec_count) - cnt0), 32'd1);

    // Reset mid-vector.
    send_vec(16'h4000, 3, -1);
    rst_n = 1'b0;
    #1;
    check("mrst_x_valid", 32'(x_valid), 32'd0);
    check("mrst_s_ready", 32'(s_ready), 32'd1);
    check("mrst_err_len", 32'(err_len), 32'd0);
    check("mrst_vec_count", 32'(vec_count), 32'd0);
    check("mrst_a_zero", 32'(a == '0), 32'd1);
    sb.delete();
    tb_beat = 0;
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send_vec(16'h4400, 8, 7);
    drain();
    check("mrst_after_vec", 32'(vec_count), 32'd1);
    check("final_err_model", 32'(err_seen), 32'(err_exp));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
